// File: rtl/alu_wb_pkg.sv
// Shared constants and the writeback record type for the ALU writeback stage.
// Build option: define ALU_WB_EXC_COUNT_EN to enable the exception event counter.
package alu_wb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_REG_W  = 5;

  localparam logic [2:0] CLS_ALU  = 3'd0;
  localparam logic [2:0] CLS_ADD  = 3'd1;
  localparam logic [2:0] CLS_ADDI = 3'd2;
  localparam logic [2:0] CLS_SUB  = 3'd3;
  localparam logic [2:0] CLS_BNE  = 3'd4;
  localparam logic [2:0] CLS_BLT  = 3'd5;
  localparam logic [2:0] CLS_NOP  = 3'd6;

  localparam logic [WB_REG_W-1:0] RSTATUS_IDX = 5'd30;

  localparam logic [1:0] EXC_ADD  = 2'd1;
  localparam logic [1:0] EXC_ADDI = 2'd2;
  localparam logic [1:0] EXC_SUB  = 2'd3;

  typedef struct packed {
    logic                 wren;
    logic [WB_REG_W-1:0]  rd;
    logic [WB_DATA_W-1:0] data;
    logic                 branch_taken;
    logic                 exc;
  } wb_rec_t;

  localparam int REC_W = $bits(wb_rec_t);

  // Status code written to $rstatus when an arithmetic class overflows.
  function automatic logic [1:0] exc_code(input logic [2:0] cls);
    logic [1:0] code;
    code = 2'd0;
    case (cls)
      CLS_ADD:  code = EXC_ADD;
      CLS_ADDI: code = EXC_ADDI;
      CLS_SUB:  code = EXC_SUB;
      default:  code = 2'd0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/alu_wb_skid.sv
// Generic 2-entry valid/ready skid buffer: an output register backed by one skid register.
// Handshake: a transfer happens on a side only in a cycle where valid && ready are both high.
module alu_wb_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q,  out_data_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] skid_data_q,  skid_data_d;
  logic         in_ready_q,   in_ready_d;

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = in_valid && in_ready_q;
  assign out_xfer = out_valid_q && out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;

    if (out_xfer || !out_valid_q) begin
      // Output register is free at this edge: refill from skid first to keep FIFO order.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (in_xfer) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_xfer) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end

    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: rtl/alu_writeback_stage.sv
// ALU writeback stage: forms a writeback/branch record per ALU result and buffers it.
// Build option: ALU_WB_EXC_COUNT_EN enables the saturating exception counter (else exc_count=0).
module alu_writeback_stage
  import alu_wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_overflow,
  input  logic              in_isNotEqual,
  input  logic              in_isLessThan,
  input  logic [2:0]        in_class,
  input  logic [REG_W-1:0]  in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_wren,
  output logic [REG_W-1:0]  out_rd,
  output logic [DATA_W-1:0] out_data,
  output logic              out_branch_taken,
  output logic              out_exc,
  output logic [CNT_W-1:0]  exc_count
);

  wb_rec_t            rec_d;
  wb_rec_t            rec_out;
  logic [REC_W-1:0]   rec_out_bits;

  always_comb begin
    rec_d = '0;
    case (in_class)
      CLS_ALU: begin
        rec_d.wren = 1'b1;
        rec_d.rd   = in_rd;
        rec_d.data = in_result;
      end
      CLS_ADD, CLS_ADDI, CLS_SUB: begin
        rec_d.wren = 1'b1;
        if (in_overflow) begin
          rec_d.rd   = RSTATUS_IDX;
          rec_d.data = {{(WB_DATA_W-2){1'b0}}, exc_code(in_class)};
          rec_d.exc  = 1'b1;
        end else begin
          rec_d.rd   = in_rd;
          rec_d.data = in_result;
        end
      end
      CLS_BNE: rec_d.branch_taken = in_isNotEqual;
      CLS_BLT: rec_d.branch_taken = in_isLessThan;
      default: rec_d = '0;
    endcase

    // r0 is hard-wired zero; the exception path always targets r30 so it is unaffected.
    if (rec_d.rd == '0) begin
      rec_d.wren = 1'b0;
    end
  end

  alu_wb_skid #(
    .W (REC_W)
  ) u_skid (
    .clk       (clock),
    .rst_n     (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (rec_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (rec_out_bits)
  );

  assign rec_out          = wb_rec_t'(rec_out_bits);
  assign out_wren         = rec_out.wren;
  assign out_rd           = rec_out.rd;
  assign out_data         = rec_out.data;
  assign out_branch_taken = rec_out.branch_taken;
  assign out_exc          = rec_out.exc;

`ifdef ALU_WB_EXC_COUNT_EN
  logic [CNT_W-1:0] exc_count_q;
  logic [CNT_W-1:0] exc_count_d;

  always_comb begin
    exc_count_d = exc_count_q;
    if (out_valid && out_ready && rec_out.exc && (exc_count_q != {CNT_W{1'b1}})) begin
      exc_count_d = exc_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      exc_count_q <= '0;
    end else begin
      exc_count_q <= exc_count_d;
    end
  end

  assign exc_count = exc_count_q;
`else
  assign exc_count = '0;
`endif

endmodule
